// File: rtl/drive_pkg.sv
// -----------------------------------------------------------------------------
// drive_pkg
//   Shared definitions for the drive command arbiter:
//     - one-hot command constants (FWD/BACK/LEFT/RIGHT/STOP)
//     - arbiter state encoding
//     - motor control bundle and the command -> motor mapping
//     - one-hot check used to reject malformed commands
// -----------------------------------------------------------------------------
package drive_pkg;

    localparam int unsigned CMD_W = 5;

    localparam logic [CMD_W-1:0] CMD_FWD   = 5'b00001;
    localparam logic [CMD_W-1:0] CMD_BACK  = 5'b00010;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 5'b00100;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 5'b01000;
    localparam logic [CMD_W-1:0] CMD_STOP  = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DWELL  = 2'd2,
        ST_MANUAL = 2'd3
    } state_e;

    // Enable/direction pair for both motor instances.
    typedef struct packed {
        logic m0_ena;
        logic m0_dir;
        logic m1_ena;
        logic m1_dir;
    } motor_t;

    // Turning is done by running the two motors in opposite directions.
    function automatic motor_t cmd_to_motor(input logic [CMD_W-1:0] cmd);
        motor_t m;
        m = '0;
        case (cmd)
            CMD_FWD:   begin m.m0_ena = 1'b1; m.m0_dir = 1'b1; m.m1_ena = 1'b1; m.m1_dir = 1'b1; end
            CMD_BACK:  begin m.m0_ena = 1'b1; m.m0_dir = 1'b0; m.m1_ena = 1'b1; m.m1_dir = 1'b0; end
            CMD_LEFT:  begin m.m0_ena = 1'b1; m.m0_dir = 1'b0; m.m1_ena = 1'b1; m.m1_dir = 1'b1; end
            CMD_RIGHT: begin m.m0_ena = 1'b1; m.m0_dir = 1'b1; m.m1_ena = 1'b1; m.m1_dir = 1'b0; end
            default:   m = '0;
        endcase
        return m;
    endfunction

    function automatic logic is_onehot5(input logic [CMD_W-1:0] v);
        logic [2:0] ones;
        ones = 3'd0;
        for (int i = 0; i < CMD_W; i++) begin
            ones = ones + {2'b00, v[i]};
        end
        return (ones == 3'd1);
    endfunction

endpackage

// File: rtl/drive_tick_timer.sv
// -----------------------------------------------------------------------------
// drive_tick_timer
//   Saturating up-counter with synchronous clear and a terminal flag.
//   last_o is high while the count sits at LIMIT-1 or above, so a caller that
//   clears the counter on entry to a state and leaves on last_o spends exactly
//   LIMIT cycles in that state. LIMIT = 0 makes last_o permanently high.
// Ports
//   clk    in  control clock
//   rst_n  in  asynchronous active-low reset
//   clr_i  in  clear count to zero (wins over en_i)
//   en_i   in  count one tick (saturates at LIMIT)
//   last_o out terminal flag
// -----------------------------------------------------------------------------
module drive_tick_timer #(
    parameter  int unsigned LIMIT = 4,
    localparam int unsigned W     = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam int unsigned LAST = (LIMIT == 0) ? 0 : LIMIT - 1;

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != W'(LIMIT))) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign last_o = (LIMIT == 0) || (count_q >= W'(LAST));

endmodule

// File: rtl/drive_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// drive_cmd_arbiter
//   Arbitrates drive commands from the tone decoder, the host link and the two
//   manual keys, and drives enable/direction of both motors. A direction change
//   always passes through a stopped dwell; a watchdog stops the motors when no
//   command refreshes a running motion.
// Ports
//   clk, rst_n            control clock, asynchronous active-low reset
//   tone_valid/tone_cmd   one-cycle strobe with one-hot command
//   host_valid/host_cmd   held-until-accepted host command
//   host_ready            host command accepted on host_valid & host_ready
//   key_n[1:0]            raw active-low manual keys (motor0, motor1)
//   m0_ena/m0_dir         motor0 control
//   m1_ena/m1_dir         motor1 control
//   cur_cmd               command being applied (STOP outside RUN)
//   busy                  high during the dwell
//   timeout               one-cycle pulse on watchdog stop
//   cmd_err               one-cycle pulse on a non-one-hot command
// -----------------------------------------------------------------------------
module drive_cmd_arbiter
    import drive_pkg::*;
#(
    parameter int unsigned DWELL_TICKS   = 31250,
    parameter int unsigned TIMEOUT_TICKS = 312500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tone_valid,
    input  logic [CMD_W-1:0] tone_cmd,
    input  logic             host_valid,
    input  logic [CMD_W-1:0] host_cmd,
    output logic             host_ready,
    input  logic [1:0]       key_n,
    output logic             m0_ena,
    output logic             m0_dir,
    output logic             m1_ena,
    output logic             m1_dir,
    output logic [CMD_W-1:0] cur_cmd,
    output logic             busy,
    output logic             timeout,
    output logic             cmd_err
);

    // ---------------------------------------------------------------- keys
    logic [1:0] key_meta_q;
    logic [1:0] key_sync_q;
    logic [1:0] key_act;

    // Released (high) is the safe reset value so the arbiter never starts in MANUAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 2'b11;
            key_sync_q <= 2'b11;
        end else begin
            key_meta_q <= key_n;
            key_sync_q <= key_meta_q;
        end
    end

    assign key_act = ~key_sync_q;

    // ---------------------------------------------------------------- state
    state_e           state_q;
    logic [CMD_W-1:0] cur_cmd_q;
    logic [CMD_W-1:0] pending_q;
    motor_t           motor_q;
    logic             busy_q;
    logic             timeout_q;
    logic             cmd_err_q;
    logic             host_ready_q;

    // ---------------------------------------------------------------- decode
    logic             host_acc;
    logic             tone_ok;
    logic             host_ok;
    logic             cmd_bad;
    logic             cmd_is_stop;
    logic             cmd_vld;
    logic [CMD_W-1:0] cmd_sel;
    logic [CMD_W-1:0] dwell_next;

    always_comb begin
        host_acc    = host_valid & host_ready_q;
        tone_ok     = tone_valid & is_onehot5(tone_cmd);
        host_ok     = host_acc & is_onehot5(host_cmd);
        cmd_bad     = (tone_valid & ~is_onehot5(tone_cmd)) |
                      (host_acc & ~is_onehot5(host_cmd));
        // STOP from either source wins; otherwise an accepted host command
        // shadows the tone strobe, even if the host command is malformed.
        cmd_is_stop = (tone_ok && (tone_cmd == CMD_STOP)) ||
                      (host_ok && (host_cmd == CMD_STOP));
        cmd_vld     = cmd_is_stop | (host_acc ? host_ok : tone_ok);
        if (cmd_is_stop) begin
            cmd_sel = CMD_STOP;
        end else if (host_acc) begin
            cmd_sel = host_cmd;
        end else begin
            cmd_sel = tone_cmd;
        end
        dwell_next = cmd_vld ? cmd_sel : pending_q;
    end

    // ---------------------------------------------------------------- timers
    logic dwell_last;
    logic wd_last;
    logic wd_expire;
    logic wd_clr;

    // Both counters sit cleared outside their state, so entry starts at zero.
    drive_tick_timer #(.LIMIT(DWELL_TICKS)) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != ST_DWELL),
        .en_i   (state_q == ST_DWELL),
        .last_o (dwell_last)
    );

    assign wd_clr = (state_q != ST_RUN) || (cmd_vld && (cmd_sel == cur_cmd_q));

    drive_tick_timer #(.LIMIT(TIMEOUT_TICKS)) u_wd_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (wd_clr),
        .en_i   (state_q == ST_RUN),
        .last_o (wd_last)
    );

    assign wd_expire = (TIMEOUT_TICKS != 0) && wd_last;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_cmd_q    <= CMD_STOP;
            pending_q    <= CMD_STOP;
            motor_q      <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
            host_ready_q <= 1'b0;
        end else begin
            timeout_q    <= 1'b0;
            cmd_err_q    <= cmd_bad;
            host_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            if (|key_act) begin
                state_q        <= ST_MANUAL;
                cur_cmd_q      <= CMD_STOP;
                pending_q      <= CMD_STOP;
                motor_q.m0_ena <= key_act[0];
                motor_q.m0_dir <= 1'b1;
                motor_q.m1_ena <= key_act[1];
                motor_q.m1_dir <= 1'b1;
                host_ready_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_vld && !cmd_is_stop) begin
                            state_q   <= ST_RUN;
                            cur_cmd_q <= cmd_sel;
                            motor_q   <= cmd_to_motor(cmd_sel);
                        end
                    end
                    ST_RUN: begin
                        if (cmd_vld) begin
                            if (cmd_is_stop) begin
                                state_q   <= ST_IDLE;
                                cur_cmd_q <= CMD_STOP;
                                motor_q   <= '0;
                            end else if (cmd_sel != cur_cmd_q) begin
                                state_q   <= ST_DWELL;
                                pending_q <= cmd_sel;
                                cur_cmd_q <= CMD_STOP;
                                motor_q   <= '0;
                                busy_q    <= 1'b1;
                            end
                        end else if (wd_expire) begin
                            state_q   <= ST_IDLE;
                            cur_cmd_q <= CMD_STOP;
                            motor_q   <= '0;
                            timeout_q <= 1'b1;
                        end
                    end
                    ST_DWELL: begin
                        if (cmd_vld && cmd_is_stop) begin
                            state_q   <= ST_IDLE;
                            pending_q <= CMD_STOP;
                        end else if (dwell_last) begin
                            // A command arriving in the final dwell cycle is honoured.
                            state_q   <= ST_RUN;
                            cur_cmd_q <= dwell_next;
                            motor_q   <= cmd_to_motor(dwell_next);
                            pending_q <= CMD_STOP;
                        end else begin
                            pending_q <= dwell_next;
                            busy_q    <= 1'b1;
                        end
                    end
                    ST_MANUAL: begin
                        // Keys released: stop, never resume the prior command.
                        state_q   <= ST_IDLE;
                        cur_cmd_q <= CMD_STOP;
                        motor_q   <= '0;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        cur_cmd_q <= CMD_STOP;
                        motor_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign m0_ena     = motor_q.m0_ena;
    assign m0_dir     = motor_q.m0_dir;
    assign m1_ena     = motor_q.m1_ena;
    assign m1_dir     = motor_q.m1_dir;
    assign cur_cmd    = cur_cmd_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
    assign cmd_err    = cmd_err_q;
    assign host_ready = host_ready_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_drive_cmd_arbiter
//   Directed bench for drive_cmd_arbiter with DWELL_TICKS=4, TIMEOUT_TICKS=16.
//   Motor outputs are compared as {m0_ena, m0_dir, m1_ena, m1_dir}.
// -----------------------------------------------------------------------------
module tb_drive_cmd_arbiter;

    localparam logic [4:0] FWD   = 5'b00001;
    localparam logic [4:0] BACK  = 5'b00010;
    localparam logic [4:0] LEFT  = 5'b00100;
    localparam logic [4:0] RIGHT = 5'b01000;
    localparam logic [4:0] STOP  = 5'b10000;

    localparam logic [3:0] MOT_OFF   = 4'b0000;
    localparam logic [3:0] MOT_FWD   = 4'b1111;
    localparam logic [3:0] MOT_BACK  = 4'b1010;
    localparam logic [3:0] MOT_LEFT  = 4'b1011;
    localparam logic [3:0] MOT_RIGHT = 4'b1110;
    localparam logic [3:0] MOT_KEY0  = 4'b1101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tone_valid;
    logic [4:0] tone_cmd;
    logic       host_valid;
    logic [4:0] host_cmd;
    logic       host_ready;
    logic [1:0] key_n;
    logic       m0_ena, m0_dir, m1_ena, m1_dir;
    logic [4:0] cur_cmd;
    logic       busy, timeout, cmd_err;

    int n_checks = 0;
    int n_fail   = 0;

    drive_cmd_arbiter #(
        .DWELL_TICKS   (4),
        .TIMEOUT_TICKS (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tone_valid (tone_valid),
        .tone_cmd   (tone_cmd),
        .host_valid (host_valid),
        .host_cmd   (host_cmd),
        .host_ready (host_ready),
        .key_n      (key_n),
        .m0_ena     (m0_ena),
        .m0_dir     (m0_dir),
        .m1_ena     (m1_ena),
        .m1_dir     (m1_dir),
        .cur_cmd    (cur_cmd),
        .busy       (busy),
        .timeout    (timeout),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] mot();
        return {m0_ena, m0_dir, m1_ena, m1_dir};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tone(input logic [4:0] c);
        tone_valid = 1'b1;
        tone_cmd   = c;
        tick(1);
        tone_valid = 1'b0;
        tone_cmd   = 5'b00000;
    endtask

    task automatic host(input logic [4:0] c);
        host_valid = 1'b1;
        host_cmd   = c;
        tick(1);
        host_valid = 1'b0;
        host_cmd   = 5'b00000;
    endtask

    initial begin
        rst_n      = 1'b0;
        tone_valid = 1'b0;
        tone_cmd   = 5'b00000;
        host_valid = 1'b0;
        host_cmd   = 5'b00000;
        key_n      = 2'b11;
        tick(3);

        // Reset state
        check("rst_mot",     mot(),      MOT_OFF);
        check("rst_cur",     cur_cmd,    STOP);
        check("rst_busy",    busy,       1'b0);
        check("rst_timeout", timeout,    1'b0);
        check("rst_err",     cmd_err,    1'b0);
        check("rst_hrdy",    host_ready, 1'b0);
        rst_n = 1'b1;
        tick(1);
        check("hrdy_rise",   host_ready, 1'b1);

        // Tone FWD, then watchdog expiry after 16 cycles in RUN
        tone(FWD);
        check("fwd_mot",     mot(),   MOT_FWD);
        check("fwd_cur",     cur_cmd, FWD);
        tick(15);
        check("wd_pre_to",   timeout, 1'b0);
        check("wd_pre_mot",  mot(),   MOT_FWD);
        tick(1);
        check("wd_pulse",    timeout, 1'b1);
        check("wd_mot",      mot(),   MOT_OFF);
        check("wd_cur",      cur_cmd, STOP);
        tick(1);
        check("wd_pulse_end", timeout, 1'b0);

        // RUN FWD, host BACK -> 4 dwell cycles then BACK
        tone(FWD);
        host(BACK);
        check("dw_mot0",   mot(),   MOT_OFF);
        check("dw_busy0",  busy,    1'b1);
        check("dw_cur0",   cur_cmd, STOP);
        tick(3);
        check("dw_busy3",  busy,    1'b1);
        check("dw_mot3",   mot(),   MOT_OFF);
        tick(1);
        check("back_mot",  mot(),   MOT_BACK);
        check("back_busy", busy,    1'b0);
        check("back_cur",  cur_cmd, BACK);

        // LEFT inside the dwell replaces pending without extending it
        host(FWD);
        check("dl_busy0",  busy, 1'b1);
        tick(1);
        tone(LEFT);
        tick(1);
        check("dl_busy3",  busy, 1'b1);
        tick(1);
        check("left_mot",  mot(),   MOT_LEFT);
        check("left_cur",  cur_cmd, LEFT);
        check("left_busy", busy,    1'b0);
        tone(STOP);
        check("stop_mot",  mot(),   MOT_OFF);
        check("stop_cur",  cur_cmd, STOP);

        // Tone STOP with host FWD in IDLE: stays IDLE, host accepted
        tone_valid = 1'b1; tone_cmd = STOP;
        host_valid = 1'b1; host_cmd = FWD;
        check("sh_hrdy", host_ready, 1'b1);
        tick(1);
        tone_valid = 1'b0; host_valid = 1'b0;
        check("sh_mot",  mot(),   MOT_OFF);
        check("sh_cur",  cur_cmd, STOP);

        // Tone FWD with host RIGHT: host wins
        tone_valid = 1'b1; tone_cmd = FWD;
        host_valid = 1'b1; host_cmd = RIGHT;
        tick(1);
        tone_valid = 1'b0; host_valid = 1'b0;
        check("right_mot", mot(),   MOT_RIGHT);
        check("right_cur", cur_cmd, RIGHT);
        host(STOP);
        check("hstop_mot", mot(),   MOT_OFF);

        // Manual key0 during RUN
        tone(FWD);
        key_n = 2'b10;
        tick(2);
        check("key_sync_mot", mot(), MOT_FWD);
        tick(1);
        check("key_mot",  mot(),      MOT_KEY0);
        check("key_hrdy", host_ready, 1'b0);
        check("key_cur",  cur_cmd,    STOP);
        tone(FWD);
        check("key_tone_ign", mot(),  MOT_KEY0);
        key_n = 2'b11;
        tick(2);
        check("rel_sync_hrdy", host_ready, 1'b0);
        tick(1);
        check("rel_mot",  mot(),      MOT_OFF);
        check("rel_hrdy", host_ready, 1'b1);
        tick(3);
        check("rel_noresume", mot(),  MOT_OFF);

        // Non-one-hot strobe in RUN
        tone(FWD);
        tone(5'b00011);
        check("err_pulse", cmd_err, 1'b1);
        check("err_mot",   mot(),   MOT_FWD);
        check("err_cur",   cur_cmd, FWD);
        check("err_busy",  busy,    1'b0);
        tick(1);
        check("err_end",   cmd_err, 1'b0);

        // Reset mid-DWELL
        host(BACK);
        check("rd_busy", busy, 1'b1);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("rd_mot",  mot(),      MOT_OFF);
        check("rd_busy_low", busy,   1'b0);
        check("rd_hrdy", host_ready, 1'b0);
        check("rd_cur",  cur_cmd,    STOP);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("rd_rel_hrdy", host_ready, 1'b1);
        tick(6);
        check("rd_rel_mot",  mot(),   MOT_OFF);
        check("rd_rel_busy", busy,    1'b0);
        check("rd_rel_cur",  cur_cmd, STOP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
